// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I main controller.
package mc_ctrl_pkg;

  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [ALUCTRL_W-1:0] ALUCTL_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALUCTL_SUB = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALUCTL_AND = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALUCTL_OR  = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore output decode; anything not set stays 0, including TRAP and unused codes.
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_EXECUTEI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (s == S_EXECUTEI) ? ALUOP_FUNCT : ALUOP_ADD;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALUOp/funct to ALUControl decode for the multicycle RV32I datapath.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 op5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALUCTL_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type sub has both op[5] and funct7[5] set; addi never subtracts
          3'b000:  alu_control = (op5 & funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control = ALUCTL_SLT;
          3'b110:  alu_control = ALUCTL_OR;
          3'b111:  alu_control = ALUCTL_AND;
          default: alu_control = ALUCTL_ADD;
        endcase
      end
      default: alu_control = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Main controller FSM for the multicycle RV32I datapath.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q & ~reset;
`else
  assign illegal = 1'b0;
`endif

  // Enables are masked by reset directly so a write in flight is killed the cycle reset rises.
  assign PCWrite   = ~reset & (ctrl_q.pc_update | (ctrl_q.branch & zero));
  assign IRWrite   = ~reset & ctrl_q.ir_write;
  assign RegWrite  = ~reset & ctrl_q.reg_write;
  assign MemWrite  = ~reset & ctrl_q.mem_write;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule
